// File: rtl/arbitro_memoria.sv
// Multicycle sequencer and single-port memory arbiter for the rv32i core.
// Optional ARB_WATCHDOG_EN adds a mem_ready watchdog with a sticky bus_err and a HALT state.
module arbitro_memoria #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WD_CYCLES = 64,
  parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       rd2,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       instruccion,
  output logic [31:0]       ReadData,
  output logic              core_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instr_count,
  output logic              bus_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DATA, COMMIT, HALT} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   daddr_q;
  logic                dwe_q;
  logic                dload_q;
  logic [31:0]         dwdata_q;
  logic                wd_trip;
  logic                unused_bits;

  assign unused_bits = ^{pc[31:ADDR_W+2], pc[1:0], ALUResult[31:ADDR_W+2], ALUResult[1:0]};

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned     WD_W    = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Any cycle that is not a stalled transfer clears the counter, so it
  // starts from zero on every entry to FETCH or DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      if ((state == FETCH || state == DATA) && !mem_ready) wd_cnt <= wd_cnt + 1'b1;
      else                                                wd_cnt <= '0;
      if (wd_trip) bus_err <= 1'b1;
    end
  end

  assign wd_trip = (state == FETCH || state == DATA) && !mem_ready && (wd_cnt == WD_LAST);
`else
  assign wd_trip = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = FETCH;
      FETCH:   if (mem_ready) state_nx = DECODE;
               else if (wd_trip) state_nx = HALT;
      DECODE:  state_nx = (MemWrite || MemRead) ? DATA : COMMIT;
      DATA:    if (mem_ready) state_nx = COMMIT;
               else if (wd_trip) state_nx = HALT;
      COMMIT:  state_nx = FETCH;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Fetch address follows pc directly: the core updates pc on the same edge
  // that leaves COMMIT, so a register loaded on that edge would see the old pc.
  always_comb begin
    mem_req   = (state == FETCH) || (state == DATA);
    mem_we    = (state == DATA) && dwe_q;
    core_en   = (state == COMMIT);
    mem_addr  = (state == FETCH) ? pc[ADDR_W+1:2] : daddr_q;
    mem_wdata = dwdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      daddr_q     <= '0;
      dwe_q       <= 1'b0;
      dload_q     <= 1'b0;
      dwdata_q    <= '0;
      instruccion <= NOP_WORD;
      ReadData    <= '0;
      instr_count <= '0;
    end else begin
      if (state == DECODE && (MemWrite || MemRead)) begin
        daddr_q  <= ALUResult[ADDR_W+1:2];
        dwe_q    <= MemWrite;
        dload_q  <= MemRead && !MemWrite;
        dwdata_q <= rd2;
      end
      if (state == FETCH && mem_ready)            instruccion <= mem_rdata;
      if (state == DATA && mem_ready && dload_q)  ReadData    <= mem_rdata;
      if (state == COMMIT)                        instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Scoreboard bench for arbitro_memoria: random instructions, random wait states, reset and watchdog scenarios.
module tb_arbitro_memoria;
  localparam int unsigned AW = 10;
  localparam int unsigned WD = 4;

  logic          clk, reset;
  logic [31:0]   pc, ALUResult, rd2;
  logic          MemWrite, MemRead;
  logic [31:0]   instruccion, ReadData, mem_wdata, mem_rdata, instr_count;
  logic          core_en, mem_req, mem_we, mem_ready, bus_err;
  logic [AW-1:0] mem_addr;

  arbitro_memoria #(.ADDR_W(AW), .WD_CYCLES(WD), .NOP_WORD(32'h00000013)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ALUResult(ALUResult), .rd2(rd2),
    .MemWrite(MemWrite), .MemRead(MemRead), .instruccion(instruccion),
    .ReadData(ReadData), .core_en(core_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .instr_count(instr_count), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  typedef struct {logic [AW-1:0] addr; logic we; logic [31:0] wdata; logic data;} xfer_t;
  typedef struct {logic [31:0] instr; logic [31:0] rd; logic [31:0] cnt; int unsigned extra;} commit_t;

  xfer_t       txq[$];
  commit_t     cq[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] exp_rd, exp_count, cur_pc;
  bit          force_load, hold_data, data_stalled, stall_all;
  int unsigned stall_cnt, commits;

  // Reference model: one instruction = fetch, optional data transfer, commit.
  task automatic gen_instr(input int kind, input logic [31:0] pcv);
    logic [31:0]   alu, wd;
    logic          rd_, wr_;
    logic [AW-1:0] pw, aw;
    xfer_t         t;
    commit_t       c;
    if (kind < 0) kind = $urandom_range(0, 3);
    alu = $urandom;
    wd  = $urandom;
    rd_ = (kind == 1) || (kind == 3);
    wr_ = (kind == 2) || (kind == 3);
    pw  = pcv[AW+1:2];
    aw  = alu[AW+1:2];
    pc = pcv; ALUResult = alu; rd2 = wd; MemRead = rd_; MemWrite = wr_; cur_pc = pcv;
    t = '{pw, 1'b0, 32'h0, 1'b0};
    txq.push_back(t);
    c.instr = ref_mem[pw];
    if (wr_) begin
      t = '{aw, 1'b1, wd, 1'b1};
      txq.push_back(t);
      ref_mem[aw] = wd;
    end else if (rd_) begin
      t = '{aw, 1'b0, 32'h0, 1'b1};
      txq.push_back(t);
      exp_rd = ref_mem[aw];
    end
    exp_count = exp_count + 32'd1;
    c.rd = exp_rd;
    c.cnt = exp_count;
    c.extra = (rd_ || wr_) ? 1 : 0;
    cq.push_back(c);
  endtask

  // Core model: next instruction presented on each commit strobe.
  always @(negedge clk) begin
    if (reset && core_en) begin
      commits++;
      gen_instr(force_load ? 1 : -1, $urandom);
      force_load = 0;
    end
  end

  // Memory model with random wait states and transfer checking.
  bit            prev_stall;
  logic [AW-1:0] p_addr;
  logic          p_we;
  logic [31:0]   p_wd;
  int unsigned   streak;
  xfer_t         mt;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0; stall_cnt = 0; streak = 0; mem_ready = 1'b0;
    end else begin
      if (prev_stall && !stall_all) begin
        chk("hold_req",   32'(mem_req),  32'd1);
        chk("hold_addr",  32'(mem_addr), 32'(p_addr));
        chk("hold_we",    32'(mem_we),   32'(p_we));
        chk("hold_wdata", mem_wdata,     p_wd);
      end
      prev_stall = 0;
      if (mem_req) begin
        if (stall_all || (hold_data && txq.size() > 0 && txq[0].data) ||
            (streak < 3 && $urandom_range(0, 2) == 0)) begin
          if (hold_data && txq.size() > 0 && txq[0].data) data_stalled = 1;
          mem_ready = 1'b0; mem_rdata = $urandom;
          streak++; stall_cnt++;
          prev_stall = 1; p_addr = mem_addr; p_we = mem_we; p_wd = mem_wdata;
        end else begin
          mem_ready = 1'b1; streak = 0;
          if (txq.size() == 0) fail_now("xfer_unexpected", "transfer with no expected request");
          else begin
            mt = txq.pop_front();
            chk("mem_addr", 32'(mem_addr), 32'(mt.addr));
            chk("mem_we",   32'(mem_we),   32'(mt.we));
            if (mt.we) chk("mem_wdata", mem_wdata, mt.wdata);
          end
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Commit monitor: held instruction, load data, latency, retired count.
  int unsigned cyc = 0, last_cyc = 0;
  bit          sync_pend = 1, cnt_pend = 0;
  logic [31:0] cnt_exp;
  commit_t     mc;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      sync_pend = 1; cnt_pend = 0;
    end else begin
      if (sync_pend) begin last_cyc = cyc - 1; sync_pend = 0; end
      if (cnt_pend) begin chk("instr_count", instr_count, cnt_exp); cnt_pend = 0; end
      if (core_en) begin
        if (cq.size() == 0) fail_now("commit_unexpected", "core_en=1 with no instruction due");
        else begin
          mc = cq.pop_front();
          chk("instruccion", instruccion, mc.instr);
          chk("ReadData", ReadData, mc.rd);
          chk("latency", cyc - last_cyc, 3 + mc.extra + stall_cnt);
          cnt_exp = mc.cnt; cnt_pend = 1;
        end
        last_cyc = cyc; stall_cnt = 0;
      end
    end
  end

  task automatic wait_commits(input int unsigned target);
    int unsigned k;
    k = 0;
    while (commits < target && k < 4000) begin @(negedge clk); k++; end
    if (commits < target) fail_now("commit_timeout", "instructions stopped retiring");
  endtask

  initial begin
    int unsigned k;
    logic [31:0] c0;
    reset = 1'b0; pc = '0; ALUResult = '0; rd2 = '0; MemWrite = 1'b0; MemRead = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    exp_rd = '0; exp_count = '0; commits = 0;
    force_load = 0; hold_data = 0; data_stalled = 0; stall_all = 0;
    for (int i = 0; i < (1 << AW); i++) begin ref_mem[i] = $urandom; mem[i] = ref_mem[i]; end
    ref_mem[0] = 32'h00500093; mem[0] = 32'h00500093;

    @(negedge clk); #1;
    chk("rst_instruccion", instruccion, 32'h00000013);
    chk("rst_ReadData", ReadData, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_instr_count", instr_count, 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);

    gen_instr(0, 32'h0);
    @(negedge clk); #1 reset = 1'b1;
    wait_commits(80);

    // Reset while a load is stalled in its data phase.
    force_load = 1;
    c0 = commits;
    k = 0;
    while (commits == c0 && k < 1000) begin @(negedge clk); k++; end
    hold_data = 1;
    k = 0;
    while (!data_stalled && k < 1000) begin @(negedge clk); k++; end
    if (!data_stalled) fail_now("data_timeout", "load data phase never reached");
    @(negedge clk); #1 reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_instruccion", instruccion, 32'h00000013);
    chk("mid_rst_instr_count", instr_count, 32'h0);
    chk("mid_rst_core_en", 32'(core_en), 32'd0);
    chk("mid_rst_ReadData", ReadData, 32'h0);
    txq.delete(); cq.delete();
    hold_data = 0; data_stalled = 0;
    exp_rd = '0; exp_count = 32'hFFFFFFFF;
    force dut.instr_count = 32'hFFFFFFFF;
    gen_instr(0, cur_pc);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 release dut.instr_count;
    wait_commits(commits + 40);

    // Memory never answers the fetch.
    @(negedge clk); #1 reset = 1'b0;
    txq.delete(); cq.delete();
    stall_all = 1;
    pc = $urandom;
    @(negedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
`ifdef ARB_WATCHDOG_EN
      chk("wd_mem_req", 32'(mem_req), (i < WD) ? 32'd1 : 32'd0);
      chk("wd_bus_err", 32'(bus_err), (i < WD) ? 32'd0 : 32'd1);
`else
      chk("wd_mem_req", 32'(mem_req), 32'd1);
      chk("wd_bus_err", 32'(bus_err), 32'd0);
`endif
      chk("wd_core_en", 32'(core_en), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
